// File: rtl/jtag_pkg.sv
// Shared TAP definitions: state codes, instruction codes, DR select decode.
// Latency: n/a (constants and a pure function only).
// Backpressure: n/a.
package jtag_pkg;

  // TAP state encodings (4-bit, 1149.1 style)
  localparam logic [3:0] ST_TLR   = 4'hF;
  localparam logic [3:0] ST_RTI   = 4'hC;
  localparam logic [3:0] ST_SELDR = 4'h7;
  localparam logic [3:0] ST_CAPDR = 4'h6;
  localparam logic [3:0] ST_SHDR  = 4'h2;
  localparam logic [3:0] ST_EX1DR = 4'h1;
  localparam logic [3:0] ST_PAUDR = 4'h3;
  localparam logic [3:0] ST_EX2DR = 4'h0;
  localparam logic [3:0] ST_UPDDR = 4'h5;
  localparam logic [3:0] ST_SELIR = 4'h4;
  localparam logic [3:0] ST_CAPIR = 4'hE;
  localparam logic [3:0] ST_SHIR  = 4'hA;
  localparam logic [3:0] ST_EX1IR = 4'h9;
  localparam logic [3:0] ST_PAUIR = 4'hB;
  localparam logic [3:0] ST_EX2IR = 4'h8;
  localparam logic [3:0] ST_UPDIR = 4'hD;

  // Instruction codes; BYPASS is all-ones at whatever IR width is used
  localparam int IR_IDCODE  = 1;
  localparam int IR_SAMPLE  = 2;
  localparam int IR_TESTSEL = 3;
  localparam int IR_BYPASS  = -1;

  // Value loaded into the IR shift register in Capture-IR (...0001)
  localparam int IR_CAPTURE = 1;

  typedef enum logic [1:0] {
    DR_BYPASS  = 2'd0,
    DR_IDCODE  = 2'd1,
    DR_SAMPLE  = 2'd2,
    DR_TESTSEL = 2'd3
  } dr_sel_e;

  // Unknown instruction codes fall back to BYPASS
  function automatic dr_sel_e dr_select(input logic [31:0] code);
    dr_sel_e sel;
    case (code)
      32'd1:   sel = DR_IDCODE;
      32'd2:   sel = DR_SAMPLE;
      32'd3:   sel = DR_TESTSEL;
      default: sel = DR_BYPASS;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/jtag_tap_fsm.sv
// 16-state TAP state machine driven by tms.
// Latency: state register updates on every rising clk edge.
// Backpressure: none; tms is consumed every cycle.
module jtag_tap_fsm
  import jtag_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       tms_i,
  output logic [3:0] state_o
);

  logic [3:0] state_q;
  logic [3:0] state_d;

  // Standard 1149.1 next-state table on tms
  always_comb begin
    state_d = ST_TLR;
    case (state_q)
      ST_TLR:   state_d = tms_i ? ST_TLR   : ST_RTI;
      ST_RTI:   state_d = tms_i ? ST_SELDR : ST_RTI;
      ST_SELDR: state_d = tms_i ? ST_SELIR : ST_CAPDR;
      ST_CAPDR: state_d = tms_i ? ST_EX1DR : ST_SHDR;
      ST_SHDR:  state_d = tms_i ? ST_EX1DR : ST_SHDR;
      ST_EX1DR: state_d = tms_i ? ST_UPDDR : ST_PAUDR;
      ST_PAUDR: state_d = tms_i ? ST_EX2DR : ST_PAUDR;
      ST_EX2DR: state_d = tms_i ? ST_UPDDR : ST_SHDR;
      ST_UPDDR: state_d = tms_i ? ST_SELDR : ST_RTI;
      ST_SELIR: state_d = tms_i ? ST_TLR   : ST_CAPIR;
      ST_CAPIR: state_d = tms_i ? ST_EX1IR : ST_SHIR;
      ST_SHIR:  state_d = tms_i ? ST_EX1IR : ST_SHIR;
      ST_EX1IR: state_d = tms_i ? ST_UPDIR : ST_PAUIR;
      ST_PAUIR: state_d = tms_i ? ST_EX2IR : ST_PAUIR;
      ST_EX2IR: state_d = tms_i ? ST_UPDIR : ST_SHIR;
      ST_UPDIR: state_d = tms_i ? ST_SELDR : ST_RTI;
      default:  state_d = ST_TLR;
    endcase
  end

  // State register; reset overrides tms
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_TLR;
    else     state_q <= state_d;
  end

  assign state_o = state_q;

endmodule

// File: rtl/jtag_tap_ctrl.sv
// TAP controller: IR, IDCODE/SAMPLE/TESTSEL/BYPASS data registers, TDO mux.
// Latency: capture/shift/update act on the edge leaving the matching state; tdo is combinational.
// Backpressure: none; one tms/tdi bit consumed per clk.
module jtag_tap_ctrl
  import jtag_pkg::*;
#(
  parameter int          WIDTH      = 32,
  parameter int          IR_WIDTH   = 4,
  parameter logic [31:0] IDCODE_VAL = 32'h1000_0001
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tms,
  input  logic                tdi,
  input  logic [WIDTH-1:0]    soc_output,
  output logic                tdo,
  output logic                tdo_en,
  output logic [3:0]          tap_state,
  output logic [IR_WIDTH-1:0] ir_out,
  output logic                test_sel,
  output logic                soc_rst
);

  logic [3:0]          state_q;
  logic [IR_WIDTH-1:0] ir_sr_q,  ir_sr_d;
  logic [IR_WIDTH-1:0] ir_q,     ir_d;
  logic [31:0]         id_sr_q,  id_sr_d;
  logic [WIDTH-1:0]    smp_sr_q, smp_sr_d;
  logic                ts_sr_q,  ts_sr_d;
  logic                byp_sr_q, byp_sr_d;
  logic                tsel_q,   tsel_d;
  logic                tlr_entry;
  logic                dr_lsb;
  dr_sel_e             dr_sel;

  jtag_tap_fsm u_fsm (
    .clk     (clk),
    .rst     (rst),
    .tms_i   (tms),
    .state_o (state_q)
  );

  // DR selection follows the updated instruction only, so an aborted IR
  // shift never disturbs which data register is live.
  assign dr_sel = dr_select(32'(ir_q));

  // Edges that land in TLR via tms; registers reset on the same edge the
  // state does so soc_rst and ir_out/test_sel change together.
  assign tlr_entry = tms && (state_q == ST_SELIR || state_q == ST_TLR);

  // Next-state for IR and DR chains: capture, shift, update per TAP state
  always_comb begin
    ir_sr_d  = ir_sr_q;
    ir_d     = ir_q;
    id_sr_d  = id_sr_q;
    smp_sr_d = smp_sr_q;
    ts_sr_d  = ts_sr_q;
    byp_sr_d = byp_sr_q;
    tsel_d   = tsel_q;
    if (tlr_entry) begin
      ir_sr_d  = '0;
      ir_d     = IR_WIDTH'(IR_IDCODE);
      id_sr_d  = '0;
      smp_sr_d = '0;
      ts_sr_d  = 1'b0;
      byp_sr_d = 1'b0;
      tsel_d   = 1'b0;
    end else begin
      case (state_q)
        ST_CAPIR: ir_sr_d = IR_WIDTH'(IR_CAPTURE);
        ST_SHIR:  ir_sr_d = {tdi, ir_sr_q[IR_WIDTH-1:1]};
        ST_UPDIR: ir_d    = ir_sr_q;
        ST_CAPDR: begin
          case (dr_sel)
            DR_IDCODE:  id_sr_d  = IDCODE_VAL;
            DR_SAMPLE:  smp_sr_d = soc_output;
            DR_TESTSEL: ts_sr_d  = tsel_q;
            default:    byp_sr_d = 1'b0;
          endcase
        end
        ST_SHDR: begin
          case (dr_sel)
            DR_IDCODE:  id_sr_d  = {tdi, id_sr_q[31:1]};
            DR_SAMPLE:  smp_sr_d = {tdi, smp_sr_q[WIDTH-1:1]};
            DR_TESTSEL: ts_sr_d  = tdi;
            default:    byp_sr_d = tdi;
          endcase
        end
        ST_UPDDR: begin
          if (dr_sel == DR_TESTSEL) tsel_d = ts_sr_q;
        end
        default: ;
      endcase
    end
  end

  // Register bank; synchronous reset puts everything in its TLR values
  always_ff @(posedge clk) begin
    if (rst) begin
      ir_sr_q  <= '0;
      ir_q     <= IR_WIDTH'(IR_IDCODE);
      id_sr_q  <= '0;
      smp_sr_q <= '0;
      ts_sr_q  <= 1'b0;
      byp_sr_q <= 1'b0;
      tsel_q   <= 1'b0;
    end else begin
      ir_sr_q  <= ir_sr_d;
      ir_q     <= ir_d;
      id_sr_q  <= id_sr_d;
      smp_sr_q <= smp_sr_d;
      ts_sr_q  <= ts_sr_d;
      byp_sr_q <= byp_sr_d;
      tsel_q   <= tsel_d;
    end
  end

  // LSB of the selected data register
  always_comb begin
    case (dr_sel)
      DR_IDCODE:  dr_lsb = id_sr_q[0];
      DR_SAMPLE:  dr_lsb = smp_sr_q[0];
      DR_TESTSEL: dr_lsb = ts_sr_q;
      default:    dr_lsb = byp_sr_q;
    endcase
  end

  assign tdo_en    = (state_q == ST_SHDR) || (state_q == ST_SHIR);
  assign tdo       = (state_q == ST_SHIR) ? ir_sr_q[0] :
                     (state_q == ST_SHDR) ? dr_lsb : 1'b0;
  assign tap_state = state_q;
  assign ir_out    = ir_q;
  assign test_sel  = tsel_q;
  assign soc_rst   = (state_q == ST_TLR);

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// Directed bench for jtag_tap_ctrl: reset, TLR escape, IDCODE, BYPASS, SAMPLE, TESTSEL, mid-shift reset.
// Latency: inputs driven 1ns after each rising edge, outputs sampled there too.
// Backpressure: n/a.
module tb_jtag_tap_ctrl;

  logic        clk;
  logic        rst;
  logic        tms;
  logic        tdi;
  logic [31:0] soc_output;
  logic        tdo;
  logic        tdo_en;
  logic [3:0]  tap_state;
  logic [3:0]  ir_out;
  logic        test_sel;
  logic        soc_rst;

  int n_chk = 0;
  int n_err = 0;

  jtag_tap_ctrl #(
    .WIDTH      (32),
    .IR_WIDTH   (4),
    .IDCODE_VAL (32'h1000_0001)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tms        (tms),
    .tdi        (tdi),
    .soc_output (soc_output),
    .tdo        (tdo),
    .tdo_en     (tdo_en),
    .tap_state  (tap_state),
    .ir_out     (ir_out),
    .test_sel   (test_sel),
    .soc_rst    (soc_rst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input logic t, input logic d);
    tms = t;
    tdi = d;
    @(posedge clk);
    #1;
  endtask

  // From RTI: walk to Shift-IR, shift a 4-bit value, pass UpdIR, land in RTI
  task automatic load_ir(input logic [3:0] val, input logic [3:0] old_ir,
                         output logic [3:0] capt);
    step(1, 0); step(1, 0); step(0, 0); step(0, 0);
    chk("ir_in_shir", 32'(tap_state), 32'hA);
    for (int i = 0; i < 4; i++) begin
      capt[i] = tdo;
      step(i == 3, val[i]);
    end
    step(1, 0);
    chk("ir_upd_hold", 32'(ir_out), 32'(old_ir));
    step(0, 0);
    chk("ir_loaded", 32'(ir_out), 32'(val));
  endtask

  // From RTI to Shift-DR
  task automatic goto_shdr_from_rti();
    step(1, 0); step(0, 0); step(0, 0);
  endtask

  logic [31:0] got32;
  logic [3:0]  got4;

  initial begin
    rst = 1'b1; tms = 1'b0; tdi = 1'b0; soc_output = 32'h0;
    @(posedge clk); #1;
    rst = 1'b0;

    // Reset state
    chk("rst_state",   32'(tap_state), 32'hF);
    chk("rst_ir",      32'(ir_out),    32'h1);
    chk("rst_socrst",  32'(soc_rst),   32'h1);
    chk("rst_tdo_en",  32'(tdo_en),    32'h0);
    chk("rst_tdo",     32'(tdo),       32'h0);
    chk("rst_testsel", 32'(test_sel),  32'h0);

    // IDCODE read straight out of reset
    step(0, 0);
    chk("rti_socrst", 32'(soc_rst), 32'h0);
    goto_shdr_from_rti();
    chk("shdr_state", 32'(tap_state), 32'h2);
    chk("shdr_tdo_en", 32'(tdo_en), 32'h1);
    for (int i = 0; i < 32; i++) begin
      got32[i] = tdo;
      step(i == 31, 1'b0);
    end
    chk("idcode", got32, 32'h1000_0001);
    chk("ex1dr_state", 32'(tap_state), 32'h1);
    chk("ex1dr_tdo_en", 32'(tdo_en), 32'h0);

    // TLR escape from Shift-DR with five tms=1
    for (int i = 0; i < 5; i++) step(1, 0);
    chk("esc1_state", 32'(tap_state), 32'hF);
    step(0, 0);
    goto_shdr_from_rti();
    chk("shdr2_state", 32'(tap_state), 32'h2);
    for (int i = 0; i < 5; i++) step(1, 0);
    chk("esc2_state", 32'(tap_state), 32'hF);
    chk("esc2_socrst", 32'(soc_rst), 32'h1);

    // IR load BYPASS, capture pattern visible on tdo
    step(0, 0);
    load_ir(4'hF, 4'h1, got4);
    chk("ir_capture", 32'(got4), 32'h1);
    goto_shdr_from_rti();
    got4 = 4'b1101;  // tdi sequence 1,0,1,1 LSB first
    begin
      logic [3:0] pat;
      logic [3:0] seen;
      pat = got4;
      for (int i = 0; i < 4; i++) begin
        seen[i] = tdo;
        step(i == 3, pat[i]);
      end
      chk("bypass_tdo", 32'(seen), 32'hA);  // 0,1,0,1
    end
    step(1, 0); step(0, 0);
    chk("bypass_no_upd", 32'(test_sel), 32'h0);

    // SAMPLE: captured once, later bus changes ignored
    load_ir(4'h2, 4'hF, got4);
    soc_output = 32'hDEAD_BEEF;
    goto_shdr_from_rti();
    soc_output = 32'h1234_5678;
    for (int i = 0; i < 32; i++) begin
      got32[i] = tdo;
      step(i == 31, 1'b0);
    end
    chk("sample", got32, 32'hDEAD_BEEF);
    step(1, 0); step(0, 0);

    // TESTSEL: update only on leaving UpdDR
    load_ir(4'h3, 4'h2, got4);
    goto_shdr_from_rti();
    chk("ts_cap0", 32'(tdo), 32'h0);
    step(1, 1);
    chk("ts_ex1", 32'(test_sel), 32'h0);
    step(0, 0);
    chk("ts_pau_state", 32'(tap_state), 32'h3);
    chk("ts_pau", 32'(test_sel), 32'h0);
    step(1, 0); step(1, 0);
    chk("ts_upd_state", 32'(tap_state), 32'h5);
    chk("ts_upd", 32'(test_sel), 32'h0);
    step(0, 0);
    chk("ts_set", 32'(test_sel), 32'h1);
    goto_shdr_from_rti();
    chk("ts_cap1", 32'(tdo), 32'h1);
    step(1, 1); step(1, 1); step(1, 1); step(1, 1);
    chk("ts_selir_state", 32'(tap_state), 32'h4);
    chk("ts_selir", 32'(test_sel), 32'h1);
    step(1, 1);
    chk("ts_tlr_state", 32'(tap_state), 32'hF);
    chk("ts_tlr_clr", 32'(test_sel), 32'h0);
    chk("ts_tlr_ir", 32'(ir_out), 32'h1);

    // Reset in the middle of an IR shift
    step(0, 0);
    step(1, 0); step(1, 0); step(0, 0); step(0, 0);
    chk("mid_shir", 32'(tap_state), 32'hA);
    step(0, 0); step(0, 1);
    rst = 1'b1;
    step(0, 0);
    rst = 1'b0;
    chk("mid_rst_state", 32'(tap_state), 32'hF);
    chk("mid_rst_ir", 32'(ir_out), 32'h1);
    chk("mid_rst_tdo_en", 32'(tdo_en), 32'h0);
    step(0, 0); step(1, 0); step(1, 0);
    chk("mid_after_ir", 32'(ir_out), 32'h1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
